// File: rtl/rsp_4ton_xbar.sv
// rsp_4ton_xbar: return-path crossbar routing response beats from 4 bank ports to N requester ports.
// Optional build macro RSP_XBAR_FIXED_PRIO_EN: fixed-priority arbiters (bank 0 highest) instead of round-robin.
module rsp_4ton_xbar #(
  parameter int unsigned N              = 8,
  parameter int unsigned PLD_WIDTH      = 32,
  localparam int unsigned DEST_W        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           in_vld,
  input  logic [PLD_WIDTH-1:0] in_pld   [3:0],
  input  logic [DEST_W-1:0]    in_dest  [3:0],
  output logic [3:0]           in_rdy,
  output logic [N-1:0]         out_vld,
  output logic [PLD_WIDTH-1:0] out_pld  [N-1:0],
  input  logic [N-1:0]         out_rdy,
  output logic [3:0]           err_dest
);

  localparam int unsigned NB = 4;
  localparam logic [DEST_W:0] N_EXT = (DEST_W+1)'(N);

  logic [PLD_WIDTH-1:0] fifo_pld  [NB][2];
  logic [DEST_W-1:0]    fifo_dest [NB][2];
  logic [NB-1:0]        rd_ptr;
  logic [NB-1:0]        wr_ptr;
  logic [1:0]           cnt       [NB];
  logic [1:0]           cnt_nxt   [NB];

  logic [NB-1:0]        push;
  logic [NB-1:0]        pop;
  logic [NB-1:0]        head_vld;
  logic [NB-1:0]        head_bad;
  logic [PLD_WIDTH-1:0] head_pld  [NB];
  logic [DEST_W-1:0]    head_dest [NB];

  logic [NB-1:0]        req       [N];
  logic [NB-1:0]        gnt       [N];
  logic [1:0]           gnt_idx   [N];
  logic [N-1:0]         gnt_any;
  logic [N-1:0]         load_en;

`ifndef RSP_XBAR_FIXED_PRIO_EN
  logic [1:0]           rr_ptr    [N];
`endif

  // FIFO heads, bad-destination detection and per-output request vectors
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      head_vld[i]  = (cnt[i] != 2'd0);
      head_pld[i]  = fifo_pld[i][rd_ptr[i]];
      head_dest[i] = fifo_dest[i][rd_ptr[i]];
      head_bad[i]  = head_vld[i] && ({1'b0, head_dest[i]} >= N_EXT);
    end
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < NB; i++) begin
        req[j][i] = head_vld[i] && !head_bad[i] && (head_dest[i] == DEST_W'(j));
      end
    end
  end

  // Per-output arbitration; a stage only grants when it is empty or draining this cycle
  always_comb begin
    logic [1:0] idx;
    idx = 2'd0;
    for (int unsigned j = 0; j < N; j++) begin
      load_en[j] = !out_vld[j] || out_rdy[j];
      gnt_any[j] = 1'b0;
      gnt_idx[j] = 2'd0;
      gnt[j]     = '0;
      for (int unsigned k = 0; k < NB; k++) begin
`ifdef RSP_XBAR_FIXED_PRIO_EN
        idx = 2'(k);
`else
        idx = rr_ptr[j] + 2'(k);
`endif
        if (load_en[j] && !gnt_any[j] && req[j][idx]) begin
          gnt_any[j] = 1'b1;
          gnt_idx[j] = idx;
        end
      end
      if (gnt_any[j]) begin
        gnt[j][gnt_idx[j]] = 1'b1;
      end
    end
  end

  // Pop on grant from any output, or immediately when the head carries a bad destination
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      push[i] = in_vld[i] && in_rdy[i];
      pop[i]  = head_bad[i];
      for (int unsigned j = 0; j < N; j++) begin
        pop[i] = pop[i] | gnt[j][i];
      end
      cnt_nxt[i] = cnt[i] + 2'(push[i]) - 2'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (push[i]) begin
        fifo_pld[i][wr_ptr[i]]  <= in_pld[i];
        fifo_dest[i][wr_ptr[i]] <= in_dest[i];
      end
    end
  end

  // in_rdy is registered from next occupancy, so it never depends on out_rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      in_rdy   <= '0;
      err_dest <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt[i] <= 2'd0;
      end
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= !wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= !rd_ptr[i];
        end
        if (head_bad[i]) begin
          err_dest[i] <= 1'b1;
        end
        cnt[i]    <= cnt_nxt[i];
        in_rdy[i] <= (cnt_nxt[i] != 2'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= '0;
      for (int unsigned j = 0; j < N; j++) begin
        out_pld[j] <= '0;
`ifndef RSP_XBAR_FIXED_PRIO_EN
        rr_ptr[j]  <= 2'd0;
`endif
      end
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        if (load_en[j]) begin
          out_vld[j] <= gnt_any[j];
        end
        if (gnt_any[j]) begin
          out_pld[j] <= head_pld[gnt_idx[j]];
`ifndef RSP_XBAR_FIXED_PRIO_EN
          rr_ptr[j]  <= gnt_idx[j] + 2'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rsp_4ton_xbar.sv
// Directed scoreboard bench for rsp_4ton_xbar (N=8 main instance, N=6 instance for bad destinations).
module tb_rsp_4ton_xbar;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 3;
  localparam int unsigned N6 = 6;

  typedef struct {
    logic [PW-1:0] pld;
    logic [DW-1:0] dest;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_vld;
  logic [PW-1:0] in_pld  [3:0];
  logic [DW-1:0] in_dest [3:0];
  logic [3:0]    in_rdy;
  logic [N-1:0]  out_vld;
  logic [PW-1:0] out_pld [N-1:0];
  logic [N-1:0]  out_rdy;
  logic [3:0]    err_dest;

  logic [3:0]    in_vld6;
  logic [PW-1:0] in_pld6  [3:0];
  logic [DW-1:0] in_dest6 [3:0];
  logic [3:0]    in_rdy6;
  logic [N6-1:0] out_vld6;
  logic [PW-1:0] out_pld6 [N6-1:0];
  logic [N6-1:0] out_rdy6;
  logic [3:0]    err_dest6;

  int compared   = 0;
  int mismatched = 0;

  beat_t         src_q [4][$];
  logic [PW-1:0] exp_q [N][$];
  logic [N-1:0]  held = '0;
  logic [PW-1:0] held_pld [N];

  rsp_4ton_xbar #(.N(N), .PLD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_pld(in_pld), .in_dest(in_dest), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy),
    .err_dest(err_dest)
  );

  rsp_4ton_xbar #(.N(N6), .PLD_WIDTH(PW)) dut6 (
    .clk(clk), .rst(rst),
    .in_vld(in_vld6), .in_pld(in_pld6), .in_dest(in_dest6), .in_rdy(in_rdy6),
    .out_vld(out_vld6), .out_pld(out_pld6), .out_rdy(out_rdy6),
    .err_dest(err_dest6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int b, input int k);
    return PW'(32'hC000_0000 | (b << 8) | k);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += src_q[i].size();
    for (int j = 0; j < N; j++) s += exp_q[j].size();
    return s;
  endfunction

  // Present queued beats, record handshakes just before the edge, return #1 after it
  task automatic step();
    logic [3:0] hs;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_vld[i]  = 1'b1;
        in_pld[i]  = src_q[i][0].pld;
        in_dest[i] = src_q[i][0].dest;
      end else begin
        in_vld[i]  = 1'b0;
        in_pld[i]  = '0;
        in_dest[i] = '0;
      end
    end
    @(negedge clk);
    hs = in_vld & in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (n < limit && pending() != 0) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 64'(pending()), 64'd0);
  endtask

  // Output monitor: scoreboard pop on handshake, and stability of held beats
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (held[j]) begin
          check($sformatf("hold%0d_vld", j), 64'(out_vld[j]), 64'd1);
          check($sformatf("hold%0d_pld", j), 64'(out_pld[j]), 64'(held_pld[j]));
        end
        if (out_vld[j] && out_rdy[j]) begin
          if (exp_q[j].size() == 0) begin
            check($sformatf("unexpected_out%0d", j), 64'(out_vld[j]), 64'd0);
          end else begin
            check($sformatf("out%0d_pld", j), 64'(out_pld[j]), 64'(exp_q[j].pop_front()));
          end
        end
        held[j]     = out_vld[j] && !out_rdy[j];
        held_pld[j] = out_pld[j];
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_vld   = '0;
    out_rdy  = '1;
    in_vld6  = '0;
    out_rdy6 = '1;
    for (int i = 0; i < 4; i++) begin
      in_pld[i]   = '0;
      in_dest[i]  = '0;
      in_pld6[i]  = '0;
      in_dest6[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_pld0", 64'(out_pld[0]), 64'd0);
    check("rst_err_dest", 64'(err_dest), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_rdy", 64'(in_rdy), 64'hF);
    check("rel_in_rdy6", 64'(in_rdy6), 64'hF);

    // Single beat: bank 2 -> out 5, two-cycle latency
    src_q[2].push_back('{32'hA5A5_0001, 3'd5});
    exp_q[5].push_back(32'hA5A5_0001);
    step();
    check("single_e0_vld", 64'(out_vld), 64'd0);
    step();
    check("single_e1_vld", 64'(out_vld), 64'h20);
    check("single_e1_pld", 64'(out_pld[5]), 64'hA5A5_0001);
    step();
    check("single_e2_vld", 64'(out_vld), 64'd0);
    drain("single", 10);

    // Contention: all banks to out 3
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        src_q[b].push_back('{mk(b, k), 3'd3});
`ifdef RSP_XBAR_FIXED_PRIO_EN
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        exp_q[3].push_back(mk(b, k));
`else
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        exp_q[3].push_back(mk(b, k));
`endif
    drain("contention", 60);

    // Backpressure: bank 0 streams to out 1 while out 1 stalls for 10 cycles
    out_rdy[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back('{mk(8, k), 3'd1});
      exp_q[1].push_back(mk(8, k));
    end
    repeat (3) step();
    check("bp_in_rdy0", 64'(in_rdy[0]), 64'd0);
    check("bp_out_vld1", 64'(out_vld[1]), 64'd1);
    check("bp_out_pld1", 64'(out_pld[1]), 64'(mk(8, 0)));
    repeat (7) step();
    check("bp_accepted", 64'(src_q[0].size()), 64'd3);
    out_rdy[1] = 1'b1;
    drain("bp", 40);

    // Head-of-line: bank 1 dest 0 blocked, dest 4 behind it must wait
    out_rdy[0] = 1'b0;
    src_q[2].push_back('{32'h0000_0F00, 3'd0});
    exp_q[0].push_back(32'h0000_0F00);
    repeat (2) step();
    src_q[1].push_back('{32'h0000_1000, 3'd0});
    src_q[1].push_back('{32'h0000_1004, 3'd4});
    exp_q[0].push_back(32'h0000_1000);
    exp_q[4].push_back(32'h0000_1004);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("hol_out4_c%0d", c), 64'(out_vld[4]), 64'd0);
    end
    out_rdy[0] = 1'b1;
    drain("hol", 20);

    // Bad destination on the N=6 instance: dest 7 dropped, dest 2 delivered
    in_vld6[3]  = 1'b1;
    in_pld6[3]  = 32'h0000_0BAD;
    in_dest6[3] = 3'd7;
    @(posedge clk);
    #1;
    in_pld6[3]  = 32'h0000_0022;
    in_dest6[3] = 3'd2;
    @(posedge clk);
    #1;
    in_vld6 = '0;
    check("bad_err_dest6", 64'(err_dest6), 64'h8);
    check("bad_out_vld6_e1", 64'(out_vld6), 64'd0);
    @(posedge clk);
    #1;
    check("bad_out_vld6_e2", 64'(out_vld6), 64'h04);
    check("bad_out_pld6", 64'(out_pld6[2]), 64'h22);
    @(posedge clk);
    #1;
    check("bad_out_vld6_e3", 64'(out_vld6), 64'd0);
    check("bad_err_dest_main", 64'(err_dest), 64'd0);

    // Reset mid-stream with FIFOs full and stages holding
    out_rdy = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 3; k++)
        src_q[b].push_back('{mk(b + 4, k), 3'(b)});
    repeat (4) step();
    check("mid_in_rdy_full", 64'(in_rdy), 64'd0);
    check("mid_out_vld", 64'(out_vld[3:0]), 64'hF);
    rst    = 1'b1;
    in_vld = '0;
    for (int b = 0; b < 4; b++) src_q[b].delete();
    for (int j = 0; j < N; j++) exp_q[j].delete();
    @(posedge clk);
    #1;
    check("mrst_out_vld", 64'(out_vld), 64'd0);
    check("mrst_err_dest6", 64'(err_dest6), 64'd0);
    check("mrst_in_rdy", 64'(in_rdy), 64'd0);
    rst = 1'b0;
    out_rdy = '1;
    @(posedge clk);
    #1;
    check("mrel_in_rdy", 64'(in_rdy), 64'hF);
    check("mrel_out_vld", 64'(out_vld), 64'd0);
    repeat (3) step();
    check("mrel_idle_out_vld", 64'(out_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
